hazard_scoreboard: RTL and testbench

//  N-way generalisation of the ID-stage forwarding/hazard logic.
//  - Keeps its own shadow copy of EX and MEM destinations, so the top only supplies ID-stage fields.
//  - Per ID way: emits operand forwarding selects and a rollback count (trailing ways to replay).
//  - Adds a MEM-stall: a multi-cycle load holds the pipe, with a sticky watchdog error.
//  - Sits between decode and the ID/EX register.

---
 rtl/hazard_scoreboard.sv | 147 ++++++++++++++
 tb/tb_hazard_scoreboard.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: N-way ID-stage forwarding selects, rollback count and MEM-load stall.
// Ports: clock/reset, ID group fields in, advance/squash/mem_load_done in; fwd_a/fwd_b/rollback/stall/err_timeout out.
module hazard_scoreboard #(
    parameter  int N_WAY        = 3,
    parameter  int REG_W        = 5,
    parameter  int MEM_WAIT_MAX = 8,
    localparam int FW_W         = $clog2(2*N_WAY+1),
    localparam int RB_W         = $clog2(N_WAY+1)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [N_WAY-1:0]       id_valid,
    input  logic [N_WAY*REG_W-1:0] id_rs1,
    input  logic [N_WAY*REG_W-1:0] id_rs2,
    input  logic [N_WAY*REG_W-1:0] id_rd,
    input  logic [N_WAY-1:0]       id_wr,
    input  logic [N_WAY-1:0]       id_load,
    input  logic                   advance,
    input  logic                   squash,
    input  logic                   mem_load_done,
    output logic [N_WAY*FW_W-1:0]  fwd_a,
    output logic [N_WAY*FW_W-1:0]  fwd_b,
    output logic [RB_W-1:0]        rollback,
    output logic                   stall,
    output logic                   err_timeout
);

    localparam int WC_W = $clog2(MEM_WAIT_MAX+1);

    logic [N_WAY-1:0]       ex_v, ex_wr, ex_ld;
    logic [N_WAY-1:0]       mem_v, mem_wr, mem_ld;
    logic [N_WAY*REG_W-1:0] ex_rd, mem_rd;
    logic [WC_W-1:0]        wait_cnt;
    logic                   err_q;

    logic [N_WAY*FW_W-1:0]  fwd_a_c, fwd_b_c;
    logic [RB_W-1:0]        rb_c;
    logic [N_WAY-1:0]       keep;
    logic                   stall_c;

    // Later loop iterations overwrite earlier ones: EX beats MEM,
    // and the highest way within a stage wins.
    function automatic logic [FW_W-1:0] fwd_sel(input logic [REG_W-1:0] src);
        logic [FW_W-1:0] s;
        s = '0;
        if (src != '0) begin
            for (int k = 0; k < N_WAY; k++)
                if (mem_v[k] && mem_wr[k] && mem_rd[k*REG_W +: REG_W] == src)
                    s = FW_W'(1 + N_WAY + k);
            for (int k = 0; k < N_WAY; k++)
                if (ex_v[k] && ex_wr[k] && ex_rd[k*REG_W +: REG_W] == src)
                    s = FW_W'(1 + k);
        end
        return s;
    endfunction

    function automatic logic way_hazard(input int i);
        logic             hz;
        logic [REG_W-1:0] s1, s2, rdj;
        hz = 1'b0;
        s1 = id_rs1[i*REG_W +: REG_W];
        s2 = id_rs2[i*REG_W +: REG_W];
        for (int k = 0; k < N_WAY; k++) begin
            if (ex_v[k] && ex_wr[k] && ex_ld[k]) begin
                if (s1 != '0 && ex_rd[k*REG_W +: REG_W] == s1) hz = 1'b1;
                if (s2 != '0 && ex_rd[k*REG_W +: REG_W] == s2) hz = 1'b1;
            end
        end
        for (int j = 0; j < N_WAY; j++) begin
            rdj = id_rd[j*REG_W +: REG_W];
            if (j < i && id_valid[j] && id_wr[j] && rdj != '0)
                if (rdj == s1 || rdj == s2) hz = 1'b1;
        end
        return hz;
    endfunction

    always_comb begin
        fwd_a_c = '0;
        fwd_b_c = '0;
        for (int i = 0; i < N_WAY; i++) begin
            fwd_a_c[i*FW_W +: FW_W] = fwd_sel(id_rs1[i*REG_W +: REG_W]);
            fwd_b_c[i*FW_W +: FW_W] = fwd_sel(id_rs2[i*REG_W +: REG_W]);
        end
    end

    // Descending scan so the oldest hazarded way sets the count.
    always_comb begin
        rb_c = '0;
        for (int i = N_WAY-1; i >= 0; i--)
            if (id_valid[i] && way_hazard(i))
                rb_c = RB_W'(N_WAY - i);
    end

    always_comb begin
        keep = '0;
        for (int i = 0; i < N_WAY; i++)
            keep[i] = (i < N_WAY - int'(rb_c));
    end

    assign stall_c = (|(mem_v & mem_ld)) && !mem_load_done;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ex_v     <= '0;
            ex_wr    <= '0;
            ex_ld    <= '0;
            ex_rd    <= '0;
            mem_v    <= '0;
            mem_wr   <= '0;
            mem_ld   <= '0;
            mem_rd   <= '0;
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else if (squash) begin
            ex_v <= '0;
            if (!stall_c) begin
                mem_v  <= ex_v;
                mem_wr <= ex_wr;
                mem_ld <= ex_ld;
                mem_rd <= ex_rd;
            end
        end else if (stall_c) begin
            if (wait_cnt != WC_W'(MEM_WAIT_MAX))
                wait_cnt <= wait_cnt + WC_W'(1);
            // Set on the edge where the count arrives at the limit.
            if (wait_cnt >= WC_W'(MEM_WAIT_MAX-1))
                err_q <= 1'b1;
        end else if (advance) begin
            mem_v    <= ex_v;
            mem_wr   <= ex_wr;
            mem_ld   <= ex_ld;
            mem_rd   <= ex_rd;
            ex_v     <= id_valid & keep;
            ex_wr    <= id_wr;
            ex_ld    <= id_load;
            ex_rd    <= id_rd;
            wait_cnt <= '0;
        end
    end

    assign fwd_a       = reset ? fwd_a_c : '0;
    assign fwd_b       = reset ? fwd_b_c : '0;
    assign rollback    = reset ? rb_c    : '0;
    assign stall       = reset && stall_c;
    assign err_timeout = reset && err_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed scenarios plus random traffic against
// an entry-list reference model of the EX/MEM shadow and hazard rules.
module tb_hazard_scoreboard;

    localparam int N    = 3;
    localparam int RW   = 5;
    localparam int MAXW = 8;
    localparam int FW   = 3;
    localparam int RB   = 2;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic [N-1:0]    id_valid, id_wr, id_load;
    logic [N*RW-1:0] id_rs1, id_rs2, id_rd;
    logic            advance, squash, mem_load_done;
    logic [N*FW-1:0] fwd_a, fwd_b;
    logic [RB-1:0]   rollback;
    logic            stall, err_timeout;

    always #5 clock = ~clock;

    hazard_scoreboard #(.N_WAY(N), .REG_W(RW), .MEM_WAIT_MAX(MAXW)) dut (
        .clock(clock), .reset(reset),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_wr(id_wr), .id_load(id_load),
        .advance(advance), .squash(squash), .mem_load_done(mem_load_done),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .rollback(rollback),
        .stall(stall), .err_timeout(err_timeout)
    );

    typedef struct { bit v; bit wr; bit ld; int rd; } ent_t;
    ent_t ex_m[N];
    ent_t mem_m[N];
    int   wcnt;
    bit   err_m;
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic int rs(bit b, int i);
        return b ? int'(id_rs2[i*RW +: RW]) : int'(id_rs1[i*RW +: RW]);
    endfunction

    function automatic bit hits(ent_t e, int src);
        return e.v && e.wr && e.rd == src && src != 0;
    endfunction

    function automatic int m_fwd(int src);
        for (int k = N-1; k >= 0; k--) if (hits(ex_m[k], src)) return 1 + k;
        for (int k = N-1; k >= 0; k--) if (hits(mem_m[k], src)) return 1 + N + k;
        return 0;
    endfunction

    function automatic bit m_stall();
        for (int k = 0; k < N; k++)
            if (mem_m[k].v && mem_m[k].ld && !mem_load_done) return 1;
        return 0;
    endfunction

    function automatic int m_rb();
        for (int i = 0; i < N; i++) begin
            if (!id_valid[i]) continue;
            for (int b = 0; b < 2; b++) begin
                int s;
                s = rs(b[0], i);
                for (int k = 0; k < N; k++)
                    if (hits(ex_m[k], s) && ex_m[k].ld) return N - i;
                for (int j = 0; j < i; j++)
                    if (id_valid[j] && id_wr[j] && int'(id_rd[j*RW +: RW]) == s && s != 0)
                        return N - i;
            end
        end
        return 0;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < N; i++) begin
            chk($sformatf("fwd_a%0d", i), 32'(fwd_a[i*FW +: FW]), reset ? m_fwd(rs(0, i)) : 0);
            chk($sformatf("fwd_b%0d", i), 32'(fwd_b[i*FW +: FW]), reset ? m_fwd(rs(1, i)) : 0);
        end
        chk("rollback", 32'(rollback), reset ? m_rb() : 0);
        chk("stall", 32'(stall), reset ? 32'(m_stall()) : 0);
        chk("err_timeout", 32'(err_timeout), reset ? 32'(err_m) : 0);
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            ex_m[k]  = '{0, 0, 0, 0};
            mem_m[k] = '{0, 0, 0, 0};
        end
        wcnt  = 0;
        err_m = 0;
    endtask

    task automatic model_update();
        bit   st;
        int   rb;
        ent_t old[N];
        if (!reset) return;
        st  = m_stall();
        rb  = m_rb();
        old = ex_m;
        if (squash) begin
            if (!st) mem_m = old;
            for (int k = 0; k < N; k++) ex_m[k].v = 0;
        end else if (st) begin
            if (wcnt < MAXW) wcnt++;
            if (wcnt == MAXW) err_m = 1;
        end else if (advance) begin
            mem_m = old;
            for (int i = 0; i < N; i++)
                ex_m[i] = '{id_valid[i] && (i < N - rb), id_wr[i], id_load[i],
                            int'(id_rd[i*RW +: RW])};
            wcnt = 0;
        end
    endtask

    task automatic settle();
        @(negedge clock);
        check_all();
    endtask

    task automatic tick();
        model_update();
        @(posedge clock);
        #1;
    endtask

    task automatic step();
        settle();
        tick();
    endtask

    task automatic clear_id();
        id_valid = '0; id_wr = '0; id_load = '0;
        id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    endtask

    task automatic set_way(int i, bit v, int r1, int r2, int rd, bit wr, bit ld);
        id_valid[i] = v;
        id_rs1[i*RW +: RW] = RW'(r1);
        id_rs2[i*RW +: RW] = RW'(r2);
        id_rd[i*RW +: RW]  = RW'(rd);
        id_wr[i]   = wr;
        id_load[i] = ld;
    endtask

    initial begin
        clear_id();
        advance = 0; squash = 0; mem_load_done = 0;
        model_reset();
        #1;
        check_all();
        repeat (2) @(posedge clock);
        #1;
        reset = 1;

        // T1: reset asserted in the middle of a MEM stall
        set_way(0, 1, 0, 0, 1, 1, 1);
        advance = 1;
        step();
        clear_id();
        step();
        repeat (5) step();
        set_way(0, 1, 1, 1, 0, 0, 0);
        reset = 0;
        #1;
        model_reset();
        chk("t1_stall", 32'(stall), 0);
        chk("t1_err", 32'(err_timeout), 0);
        chk("t1_fwd_a", 32'(fwd_a), 0);
        chk("t1_fwd_b", 32'(fwd_b), 0);
        @(posedge clock);
        #1;
        reset = 1;
        settle();
        chk("t1_post_fwd", 32'(fwd_a[0 +: FW]), 0);
        tick();

        // T2: EX way1 beats MEM way2 on x5
        mem_load_done = 1;
        clear_id();
        set_way(2, 1, 0, 0, 5, 1, 0);
        step();
        clear_id();
        set_way(1, 1, 0, 0, 5, 1, 0);
        step();
        clear_id();
        set_way(0, 1, 5, 0, 0, 0, 0);
        advance = 0;
        settle();
        chk("t2_ex_prio", 32'(fwd_a[0 +: FW]), 2);
        tick();

        // T3: load-use at way1 replays ways 1-2
        clear_id();
        set_way(2, 1, 0, 0, 7, 1, 1);
        advance = 1;
        step();
        clear_id();
        set_way(0, 1, 0, 0, 9, 1, 0);
        set_way(1, 1, 0, 7, 10, 1, 0);
        set_way(2, 1, 0, 0, 11, 1, 0);
        settle();
        chk("t3_rollback", 32'(rollback), 2);
        tick();
        clear_id();
        set_way(0, 1, 9, 10, 0, 0, 0);
        set_way(1, 1, 11, 0, 0, 0, 0);
        advance = 0;
        settle();
        chk("t3_ex0_valid", 32'(fwd_a[0 +: FW]), 1);
        chk("t3_ex1_bubble", 32'(fwd_b[0 +: FW]), 0);
        chk("t3_ex2_bubble", 32'(fwd_a[FW +: FW]), 0);
        tick();

        // T4: in-group RAW, and the x0 variant
        clear_id();
        set_way(0, 1, 0, 0, 3, 1, 0);
        set_way(2, 1, 3, 0, 0, 0, 0);
        settle();
        chk("t4_raw", 32'(rollback), 1);
        tick();
        clear_id();
        set_way(0, 1, 0, 0, 0, 1, 0);
        set_way(2, 1, 0, 0, 0, 0, 0);
        settle();
        chk("t4_x0", 32'(rollback), 0);
        tick();

        // T5: load held in MEM for eight cycles
        clear_id();
        set_way(0, 1, 0, 0, 4, 1, 1);
        advance = 1;
        step();
        clear_id();
        set_way(1, 1, 0, 0, 6, 1, 0);
        step();
        clear_id();
        set_way(0, 1, 4, 6, 0, 0, 0);
        mem_load_done = 0;
        for (int c = 0; c < MAXW; c++) begin
            settle();
            chk($sformatf("t5_stall_c%0d", c), 32'(stall), 1);
            chk($sformatf("t5_err_c%0d", c), 32'(err_timeout), 0);
            chk($sformatf("t5_mem_held_c%0d", c), 32'(fwd_a[0 +: FW]), 4);
            chk($sformatf("t5_ex_held_c%0d", c), 32'(fwd_b[0 +: FW]), 2);
            tick();
        end
        mem_load_done = 1;
        settle();
        chk("t5_done_stall", 32'(stall), 0);
        chk("t5_err_set", 32'(err_timeout), 1);
        tick();
        settle();
        chk("t5_err_sticky", 32'(err_timeout), 1);
        tick();

        // T6: squash with EX full
        clear_id();
        set_way(0, 1, 0, 0, 11, 1, 0);
        set_way(1, 1, 0, 0, 12, 1, 0);
        set_way(2, 1, 0, 0, 13, 1, 0);
        step();
        clear_id();
        squash = 1;
        step();
        squash = 0;
        advance = 0;
        set_way(0, 1, 11, 0, 0, 0, 0);
        set_way(1, 1, 12, 0, 0, 0, 0);
        set_way(2, 1, 13, 0, 0, 0, 0);
        settle();
        chk("t6_mem0", 32'(fwd_a[0 +: FW]), 4);
        chk("t6_mem1", 32'(fwd_a[FW +: FW]), 5);
        chk("t6_mem2", 32'(fwd_a[2*FW +: FW]), 6);
        tick();

        // Random traffic over a small register range to provoke matches
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++)
                set_way(i, ($urandom % 4) != 0, $urandom % 4, $urandom % 4,
                        $urandom % 4, $urandom % 2, ($urandom % 3) == 0);
            advance       = ($urandom % 4) != 0;
            squash        = ($urandom % 10) == 0;
            mem_load_done = ($urandom % 3) == 0;
            if (c == 200) begin
                reset = 0;
                #1;
                model_reset();
                check_all();
                @(posedge clock);
                #1;
                reset = 1;
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
